// File: rtl/pll_lock_if.sv
// pll_lock_if: bundle between the PLL lock sequencer and the PLL/system side
interface pll_lock_if #(parameter int MAX_RETRIES = 3);
  localparam int RW = MAX_RETRIES > 0 ? $clog2(MAX_RETRIES + 1) : 1;
  logic restart, pll_lock, pll_pwd, pll_reset, pll_ready, sys_rst, fault;
  logic [RW-1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state_dbg;
  modport master(
    input restart, pll_lock,
    output pll_pwd, pll_reset, pll_ready, sys_rst, fault, retry_cnt, lock_loss_cnt, state_dbg
  );
  modport slave(
    output restart, pll_lock,
    input pll_pwd, pll_reset, pll_ready, sys_rst, fault, retry_cnt, lock_loss_cnt, state_dbg
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: power-up/recovery sequencing of a PLL (PLLPWD, RESET, lock watch)
// with timeout retries, lock-loss recovery and a held system reset until lock is stable.
module pll_lock_sequencer #(
  parameter int PWD_CYCLES   = 16,
  parameter int RST_CYCLES   = 64,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRIES  = 3
) (
  input logic clkin,
  input logic reset,
  pll_lock_if.master bus
);
  localparam int RW = MAX_RETRIES > 0 ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int M1 = PWD_CYCLES > RST_CYCLES ? PWD_CYCLES : RST_CYCLES;
  localparam int M2 = LOCK_TIMEOUT > LOCK_STABLE ? LOCK_TIMEOUT : LOCK_STABLE;
  localparam int CW = $clog2((M1 > M2 ? M1 : M2) + 1);
  typedef enum logic [2:0] {
    PWD = 3'd0, RST = 3'd1, WAIT = 3'd2, STABLE = 3'd3, RUN = 3'd4, FAULT = 3'd5
  } state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [RW-1:0] retry;
  logic [7:0] loss;
  logic lock_m, lock_s;
  logic pwd_done, rst_done, tmo, stb_done, give_up;
  assign pwd_done = cnt == CW'(PWD_CYCLES - 1);
  assign rst_done = cnt == CW'(RST_CYCLES - 1);
  assign tmo      = cnt == CW'(LOCK_TIMEOUT - 1);
  assign stb_done = cnt == CW'(LOCK_STABLE - 1);
  assign give_up  = retry == RW'(MAX_RETRIES);
  always_ff @(posedge clkin or posedge reset)
    if (reset) begin
      state  <= PWD;
      cnt    <= '0;
      retry  <= '0;
      loss   <= '0;
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= bus.pll_lock;
      lock_s <= lock_m;
      state  <= nxt;
      cnt    <= (nxt != state || bus.restart) ? '0 : cnt + 1'b1;
      retry  <= (bus.restart || (nxt == RUN && state != RUN)) ? '0 :
                (state == WAIT && nxt == PWD) ? retry + 1'b1 : retry;
      // only a genuine lock loss counts; a restart out of RUN does not
      loss   <= (state == RUN && nxt == PWD && !bus.restart && loss != 8'hFF) ? loss + 1'b1 : loss;
    end
  always_comb begin
    nxt = state;
    if (bus.restart) nxt = PWD;
    else
      case (state)
        PWD:     nxt = pwd_done ? RST : PWD;
        RST:     nxt = rst_done ? WAIT : RST;
        WAIT:    nxt = lock_s ? STABLE : tmo ? (give_up ? FAULT : PWD) : WAIT;
        STABLE:  nxt = !lock_s ? WAIT : stb_done ? RUN : STABLE;
        RUN:     nxt = lock_s ? RUN : PWD;
        FAULT:   nxt = FAULT;
        default: nxt = PWD;
      endcase
  end
  assign bus.pll_pwd       = state == PWD || state == FAULT;
  assign bus.pll_reset     = state == PWD || state == RST || state == FAULT;
  assign bus.pll_ready     = state == RUN;
  assign bus.sys_rst       = state != RUN;
  assign bus.fault         = state == FAULT;
  assign bus.retry_cnt     = retry;
  assign bus.lock_loss_cnt = loss;
  assign bus.state_dbg     = state;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: randomized lock waveforms; expected output events come from
// timeline arithmetic (attempt windows) and are checked by a separate monitor.
module tb_pll_lock_sequencer;
  localparam int P = 4, R = 8, T = 100, STB = 16, MAXR = 2, S = P + R + T;
  typedef struct {int kind; int at; int retry; int llc;} ev_t;
  typedef struct {int at; logic val;} lk_t;
  logic clkin = 1'b0, reset = 1'b1;
  int cyc = 0;
  int n_cmp = 0, n_bad = 0;
  int seq_start = 0, llc_m = 0;
  bit in_run = 0, mon_en = 0;
  ev_t exp_q[$];
  lk_t lk_q[$];
  pll_lock_if #(.MAX_RETRIES(MAXR)) bus();
  pll_lock_sequencer #(
    .PWD_CYCLES(P), .RST_CYCLES(R), .LOCK_TIMEOUT(T), .LOCK_STABLE(STB), .MAX_RETRIES(MAXR)
  ) dut (.clkin(clkin), .reset(reset), .bus(bus));
  always #5 clkin = ~clkin;
  always @(posedge clkin) cyc <= cyc + 1;
  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction
  // kinds: 0 pwd falls, 1 ready rises, 2 ready falls, 3 fault rises
  initial begin : monitor
    int k;
    ev_t e;
    logic p_pwd, p_rdy, p_flt;
    p_pwd = 1'b1; p_rdy = 1'b0; p_flt = 1'b0;
    forever begin
      @(negedge clkin);
      k = -1;
      if (p_pwd && !bus.pll_pwd) k = 0;
      else if (!p_rdy && bus.pll_ready) k = 1;
      else if (p_rdy && !bus.pll_ready) k = 2;
      else if (!p_flt && bus.fault) k = 3;
      p_pwd = bus.pll_pwd; p_rdy = bus.pll_ready; p_flt = bus.fault;
      if (mon_en && k >= 0) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", k, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", k, e.kind);
          chk("event_cycle", cyc, e.at);
          chk("retry_cnt", int'(bus.retry_cnt), e.retry);
          chk("lock_loss_cnt", int'(bus.lock_loss_cnt), e.llc);
          chk("sys_rst", int'(bus.sys_rst), k == 1 ? 0 : 1);
          if (k == 1) begin
            chk("run_pwd", int'(bus.pll_pwd), 0);
            chk("run_reset", int'(bus.pll_reset), 0);
            chk("run_state", int'(bus.state_dbg), 4);
          end
          if (k == 3) begin
            chk("fault_pwd", int'(bus.pll_pwd), 1);
            chk("fault_reset", int'(bus.pll_reset), 1);
            chk("fault_state", int'(bus.state_dbg), 5);
          end
        end
      end
    end
  end
  task automatic push(int kind, int rel, int retry);
    exp_q.push_back('{kind, seq_start + rel, retry, llc_m});
  endtask
  // L: sequence cycle at which the synchronised lock first reads high (and stays high)
  task automatic plan(int L);
    for (int k = 0; k <= MAXR; k++) begin
      int ws, n;
      ws = k * S + P + R;
      push(0, k * S + P, k);
      n = L > ws ? L : ws;
      if (n <= ws + T - 1) begin
        push(1, n + 1 + STB, 0);
        in_run = 1;
        return;
      end
    end
    push(3, (MAXR + 1) * S, MAXR);
    in_run = 0;
  endtask
  task automatic tick();
    @(negedge clkin);
    while (lk_q.size() != 0 && lk_q[0].at <= cyc) begin
      bus.pll_lock = lk_q[0].val;
      void'(lk_q.pop_front());
    end
  endtask
  task automatic drain();
    int b;
    b = 0;
    while ((exp_q.size() != 0 || lk_q.size() != 0) && b < 4 * S + 200) begin
      tick();
      b++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || lk_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending events expected 0", exp_q.size());
      exp_q.delete();
      lk_q.delete();
    end
  endtask
  task automatic kick();
    tick();
    bus.restart = 1'b1;
    bus.pll_lock = 1'b0;
    seq_start = cyc + 1;
    if (in_run) push(2, 0, 0);
    in_run = 0;
    tick();
    bus.restart = 1'b0;
    chk("restart_fault", int'(bus.fault), 0);
    chk("restart_retry", int'(bus.retry_cnt), 0);
    chk("restart_state", int'(bus.state_dbg), 0);
  endtask
  task automatic scen_lock(int m);
    if (m >= 0) lk_q.push_back('{seq_start + m, 1'b1});
    plan(m >= 0 ? m + 2 : 1 << 30);
    drain();
  endtask
  task automatic scen_loss(int d);
    int q;
    tick();
    q = cyc;
    bus.pll_lock = 1'b0;
    llc_m = llc_m < 255 ? llc_m + 1 : 255;
    seq_start = q + 3;
    push(2, 0, 0);
    lk_q.push_back('{q + d, 1'b1});
    plan(d - 1);
    drain();
  endtask
  task automatic scen_glitch(int m, int g, int h);
    lk_q.push_back('{seq_start + m, 1'b1});
    lk_q.push_back('{seq_start + m + g, 1'b0});
    lk_q.push_back('{seq_start + m + g + h, 1'b1});
    push(0, P, 0);
    push(1, m + g + h + 3 + STB, 0);
    in_run = 1;
    drain();
  endtask
  task automatic reset_check();
    #3;
    mon_en = 0;
    reset = 1'b1;
    #1;
    chk("rst_pwd", int'(bus.pll_pwd), 1);
    chk("rst_reset", int'(bus.pll_reset), 1);
    chk("rst_ready", int'(bus.pll_ready), 0);
    chk("rst_sys_rst", int'(bus.sys_rst), 1);
    chk("rst_fault", int'(bus.fault), 0);
    chk("rst_retry", int'(bus.retry_cnt), 0);
    chk("rst_llc", int'(bus.lock_loss_cnt), 0);
    chk("rst_state", int'(bus.state_dbg), 0);
    exp_q.delete();
    lk_q.delete();
    llc_m = 0;
    in_run = 0;
    tick();
    bus.pll_lock = 1'b0;
    bus.restart = 1'b0;
    tick();
    reset = 1'b0;
    seq_start = cyc;
    mon_en = 1;
  endtask
  function automatic int rand_m();
    return ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 3 * S - 1));
  endfunction
  initial begin
    bus.restart = 1'b0;
    bus.pll_lock = 1'b0;
    tick();
    reset_check();
    scen_lock(20);
    kick();
    scen_lock(-1);
    kick();
    scen_lock(30);
    scen_loss(5);
    kick();
    scen_glitch(P + R + 5, 10, 4);
    kick();
    push(0, P, 0);
    while (cyc < seq_start + P + R + 49) tick();
    kick();
    scen_lock(rand_m());
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0: begin kick(); scen_lock(rand_m()); end
        1: if (in_run) scen_loss(int'($urandom_range(3, 8)));
           else begin kick(); scen_lock(int'($urandom_range(1, 3 * S - 3))); end
        default: begin
          kick();
          scen_glitch(int'($urandom_range(P + R - 2, P + R + T - 3)),
                      int'($urandom_range(1, STB)), int'($urandom_range(1, 20)));
        end
      endcase
    end
    kick();
    lk_q.push_back('{seq_start + P + R - 2, 1'b1});
    push(0, P, 0);
    while (cyc < seq_start + P + R + 6) tick();
    reset_check();
    scen_lock(int'($urandom_range(1, 2 * S)));
    if (!in_run) begin kick(); scen_lock(5); end
    repeat (7) tick();
    reset_check();
    scen_lock(3);
    for (int i = 0; i < 260; i++) scen_loss(int'($urandom_range(3, 5)));
    chk("llc_saturated", int'(bus.lock_loss_cnt), 255);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end
endmodule
